hazard_ctrl_unit: RTL and testbench
===================================

Name: hazard_ctrl_unit

Overview:
- Next-generation hazard/forwarding controller for the in-order RISC-V pipeline.
- Keeps its own registered shadow of the EX, MEM and WB destination info, fed from decode plus stall/flush events.
- Produces EX operand forward selects for NUM_SRC sources, load-use and JALR stalls with JALR forward selects, and a multi-cycle-op busy counter that freezes the front end.
- Replaces the purely combinational forwarding logic; fixes MEM/WB suppression so it is per-register, not global.

Parameters:
REG_IDX_WIDTH, 5, register index width (x0 is index 0)
NUM_SRC, 2, source operands per instruction
FWD_SEL_WIDTH, 2, forward select width
MC_LATENCY, 4, EX cycles of a multi-cycle op (>=2)
CNT_WIDTH, $clog2(MC_LATENCY), busy counter width (localparam)

Ports:
clk  in  1  pipeline clock
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  ID holds a real instruction
id_rd  in  REG_IDX_WIDTH  ID destination
id_reg_write  in  1  ID instruction writes rd
id_is_load  in  1  ID instruction is a load
id_is_mc  in  1  ID instruction is multi-cycle (mul/div)
id_is_jalr  in  1  ID instruction is JALR (uses source 0)
id_rs  in  NUM_SRC*REG_IDX_WIDTH  ID sources; source i at bits [i*W +: W]
id_rs_used  in  NUM_SRC  per-source use mask
flush_id_ex  in  1  squash the instruction entering EX (mispredict)
stall_front  out  1  hold PC and IF/ID
bubble_ex  out  1  insert bubble into ID/EX
ex_hold  out  1  hold ID/EX and EX; bubble EX/MEM (multi-cycle in progress)
fwd_sel  out  NUM_SRC*FWD_SEL_WIDTH  EX operand selects
jalr_fwd_sel  out  FWD_SEL_WIDTH  ID JALR target select
mc_busy  out  1  multi-cycle unit occupied

Behaviour:
- Shadow stages EX, MEM and WB, each holding {valid, rd, reg_write, is_load, is_mc, rs[NUM_SRC], rs_used}.
- A stage is a "writer" iff valid & reg_write & rd!=0.
- Reset (async, rst_n=0): all shadow valid=0, counter=0.
  - Hence all outputs 0, and fwd_sel/jalr_fwd_sel = 00.
  - Reset mid multi-cycle abandons the op.
- Select encoding: 10 = from EX/MEM, 01 = from MEM/WB, 00 = regfile.
- fwd_sel[i] (combinational, for the EX instruction):
  - 10 if MEM is a writer & MEM.rd==EX.rs[i] & EX.rs_used[i].
  - Else 01 if WB is a writer & WB.rd==EX.rs[i].
  - Else 00.
  - Forced 00 when EX invalid.
- load_use: EX writer & EX.is_load & some used ID source equals EX.rd.
- jalr_stall: id_valid & id_is_jalr, and either:
  - EX writer & EX.rd==id_rs[0], or
  - MEM writer & MEM.is_load & MEM.rd==id_rs[0].
- jalr_fwd_sel: for ID JALR, 10 if MEM writer matches rs0, else 01 if WB writer matches, else 00.
- Multi-cycle:
  - When an is_mc instruction enters EX, counter loads MC_LATENCY-1.
  - mc_busy = counter!=0.
  - While mc_busy: ex_hold=1, stall_front=1, bubble_ex=0.
  - Decrement by 1 each cycle; the op leaves EX on the cycle after counter reaches 0.
  - Total EX occupancy is MC_LATENCY cycles.
- Output equations:
  - stall_front = mc_busy | load_use | jalr_stall.
  - bubble_ex = ~mc_busy & (load_use | jalr_stall | flush_id_ex).
- Shadow advance each clk:
  - mc_busy: EX holds, MEM<=bubble, WB<=MEM.
  - else if bubble_ex: EX<=bubble, MEM<=EX, WB<=MEM.
  - else: EX<=ID fields (valid=id_valid), MEM<=EX, WB<=MEM.
- Priority:
  - flush_id_ex during mc_busy is ignored (flush originates in EX, which is frozen).
  - flush_id_ex together with load_use yields one bubble only.
- x0 never forwards and never stalls.
- Forwarding from MEM when MEM is a load cannot occur: load-use stall guarantees it.
- Unused sources (mask 0) never stall and select 00.

Decomposition:
- Package hazard_pkg: FWD_REGFILE/FWD_MEM_WB/FWD_EX_MEM constants, and the shadow-stage struct typedef.
- One sub-module: hazard_fwd_match (one source index vs MEM/WB shadows -> select), instantiated NUM_SRC+1 times (EX sources plus the JALR path).

Test Plan:
1. Reset: rst_n low mid-stream with EX load -> all outputs 0 immediately; after release, no stall until new instructions.
2. add x5 then sub x6,x5,x5 back-to-back -> next cycle fwd_sel = {10,10}. One gap -> {01,01}. Same rd x5 in MEM and WB -> 10 (MEM wins).
3. lw x7 followed by add x8,x7,x1 -> exactly 1 cycle of stall_front=1 and bubble_ex=1, then fwd_sel[0]=01. Source x0 after lw x0 -> no stall.
4. div x9 (MC_LATENCY=4) then add x10,x9,x2 -> mc_busy/ex_hold high 3 cycles, no bubble. Then add reaches EX with fwd_sel[0]=10.
5. addi x1 then jalr x0,0(x1) -> 1 stall, then jalr_fwd_sel=10. lw x1 then jalr -> 2 stalls, then 01.
6. flush_id_ex with add x5 in ID -> EX bubble. Following use of x5 gets fwd_sel 00. flush during mc_busy -> ignored.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard/forwarding controller.
// Holds the forward-select encodings and the shadow pipeline-stage record.
package hazard_pkg;

    localparam int HZ_REG_IDX_W  = 5;
    localparam int HZ_NUM_SRC    = 2;
    localparam int HZ_FWD_SEL_W  = 2;

    localparam logic [HZ_FWD_SEL_W-1:0] FWD_REGFILE = 2'b00;
    localparam logic [HZ_FWD_SEL_W-1:0] FWD_MEM_WB  = 2'b01;
    localparam logic [HZ_FWD_SEL_W-1:0] FWD_EX_MEM  = 2'b10;

    typedef struct packed {
        logic                                  valid;
        logic [HZ_REG_IDX_W-1:0]               rd;
        logic                                  reg_write;
        logic                                  is_load;
        logic                                  is_mc;
        logic [HZ_NUM_SRC-1:0][HZ_REG_IDX_W-1:0] rs;
        logic [HZ_NUM_SRC-1:0]                 rs_used;
    } stage_t;

    // A stage produces a result only if it is real, writes, and is not x0.
    function automatic logic writes_reg(stage_t s, logic [HZ_REG_IDX_W-1:0] idx);
        return s.valid & s.reg_write & (s.rd != '0) & (s.rd == idx);
    endfunction

endpackage

// File: rtl/hazard_ctrl_unit_if.sv
// Decode-side inputs and hazard-control outputs of the hazard controller.
// slave is the controller's view, master is the pipeline's view.
interface hazard_ctrl_unit_if #(
    parameter int REG_IDX_WIDTH = 5,
    parameter int NUM_SRC       = 2,
    parameter int FWD_SEL_WIDTH = 2
);
    logic                              id_valid;
    logic [REG_IDX_WIDTH-1:0]          id_rd;
    logic                              id_reg_write;
    logic                              id_is_load;
    logic                              id_is_mc;
    logic                              id_is_jalr;
    logic [NUM_SRC*REG_IDX_WIDTH-1:0]  id_rs;
    logic [NUM_SRC-1:0]                id_rs_used;
    logic                              flush_id_ex;
    logic                              stall_front;
    logic                              bubble_ex;
    logic                              ex_hold;
    logic [NUM_SRC*FWD_SEL_WIDTH-1:0]  fwd_sel;
    logic [FWD_SEL_WIDTH-1:0]          jalr_fwd_sel;
    logic                              mc_busy;

    modport slave (
        input  id_valid, id_rd, id_reg_write, id_is_load, id_is_mc, id_is_jalr,
               id_rs, id_rs_used, flush_id_ex,
        output stall_front, bubble_ex, ex_hold, fwd_sel, jalr_fwd_sel, mc_busy
    );

    modport master (
        output id_valid, id_rd, id_reg_write, id_is_load, id_is_mc, id_is_jalr,
               id_rs, id_rs_used, flush_id_ex,
        input  stall_front, bubble_ex, ex_hold, fwd_sel, jalr_fwd_sel, mc_busy
    );
endinterface

// File: rtl/hazard_fwd_match.sv
// Picks the forwarding source for one register index against the MEM and WB
// shadows; the younger MEM result wins when both hold the same rd.
module hazard_fwd_match
    import hazard_pkg::*;
(
    input  logic [HZ_REG_IDX_W-1:0] src,
    input  logic                    src_used,
    input  stage_t                  mem_stage,
    input  stage_t                  wb_stage,
    output logic [HZ_FWD_SEL_W-1:0] sel
);
    always_comb begin
        sel = FWD_REGFILE;
        if (src_used && writes_reg(mem_stage, src)) begin
            sel = FWD_EX_MEM;
        end else if (src_used && writes_reg(wb_stage, src)) begin
            sel = FWD_MEM_WB;
        end
    end
endmodule

// File: rtl/hazard_ctrl_unit.sv
// Hazard/forwarding controller: registered EX/MEM/WB shadows, operand and JALR
// forward selects, load-use/JALR stalls and a multi-cycle busy down-counter.
module hazard_ctrl_unit
    import hazard_pkg::*;
#(
    parameter int REG_IDX_WIDTH = HZ_REG_IDX_W,
    parameter int NUM_SRC       = HZ_NUM_SRC,
    parameter int FWD_SEL_WIDTH = HZ_FWD_SEL_W,
    parameter int MC_LATENCY    = 4
) (
    input logic               clk,
    input logic               rst_n,
    hazard_ctrl_unit_if.slave hz
);
    localparam int CNT_WIDTH = $clog2(MC_LATENCY);
    localparam logic [CNT_WIDTH-1:0] MC_LOAD = CNT_WIDTH'(MC_LATENCY - 1);

    stage_t ex_q, ex_d, mem_q, mem_d, wb_q, wb_d, id_stage;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic mc_busy, load_use, jalr_stall, bubble_ex;
    logic [NUM_SRC-1:0][FWD_SEL_WIDTH-1:0] fwd_sel_ex;
    logic [FWD_SEL_WIDTH-1:0] jalr_sel;

    always_comb begin
        id_stage           = '0;
        id_stage.valid     = hz.id_valid;
        id_stage.rd        = hz.id_rd;
        id_stage.reg_write = hz.id_reg_write;
        id_stage.is_load   = hz.id_is_load;
        id_stage.is_mc     = hz.id_is_mc;
        id_stage.rs_used   = hz.id_rs_used;
        for (int i = 0; i < NUM_SRC; i++) begin
            id_stage.rs[i] = hz.id_rs[i*REG_IDX_WIDTH +: REG_IDX_WIDTH];
        end
    end

    always_comb begin
        load_use = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (id_stage.rs_used[i] && ex_q.is_load && writes_reg(ex_q, id_stage.rs[i])) begin
                load_use = 1'b1;
            end
        end
    end

    // The JALR target is needed in ID, so an EX result or a MEM load is too late.
    assign jalr_stall = hz.id_valid & hz.id_is_jalr &
                        (writes_reg(ex_q, id_stage.rs[0]) |
                         (mem_q.is_load & writes_reg(mem_q, id_stage.rs[0])));

    assign mc_busy   = (cnt_q != '0);
    assign bubble_ex = ~mc_busy & (load_use | jalr_stall | hz.flush_id_ex);

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_ex_fwd
        hazard_fwd_match u_match (
            .src       (ex_q.rs[g]),
            .src_used  (ex_q.valid & ex_q.rs_used[g]),
            .mem_stage (mem_q),
            .wb_stage  (wb_q),
            .sel       (fwd_sel_ex[g])
        );
    end

    hazard_fwd_match u_jalr_match (
        .src       (id_stage.rs[0]),
        .src_used  (hz.id_valid & hz.id_is_jalr),
        .mem_stage (mem_q),
        .wb_stage  (wb_q),
        .sel       (jalr_sel)
    );

    assign hz.stall_front  = mc_busy | load_use | jalr_stall;
    assign hz.bubble_ex    = bubble_ex;
    assign hz.ex_hold      = mc_busy;
    assign hz.mc_busy      = mc_busy;
    assign hz.fwd_sel      = fwd_sel_ex;
    assign hz.jalr_fwd_sel = jalr_sel;

    // While busy the op sits in EX; the final EX cycle is the one with count 0.
    always_comb begin
        ex_d  = ex_q;
        mem_d = ex_q;
        wb_d  = mem_q;
        cnt_d = cnt_q;
        if (mc_busy) begin
            mem_d = '0;
            cnt_d = cnt_q - 1'b1;
        end else if (bubble_ex) begin
            ex_d = '0;
        end else begin
            ex_d = id_stage;
            if (id_stage.valid && id_stage.is_mc) begin
                cnt_d = MC_LOAD;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
            cnt_q <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit: each cycle's vector pushes its expected
// outputs into a queue that a negedge monitor pops and compares.
module tb_hazard_ctrl_unit;
    import hazard_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hazard_ctrl_unit_if #(.REG_IDX_WIDTH(5), .NUM_SRC(2), .FWD_SEL_WIDTH(2)) hz ();

    hazard_ctrl_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz)
    );

    typedef struct packed {
        logic       v;
        logic [4:0] rd;
        logic       rw, ld, mc, jr;
        logic [4:0] rs0, rs1;
        logic [1:0] used;
    } id_t;

    // {stall_front, bubble_ex, ex_hold, mc_busy, fwd_sel[3:0], jalr_fwd_sel[1:0]}
    typedef struct packed {
        logic       stall, bubble, hold, busy;
        logic [3:0] fwd;
        logic [1:0] jfwd;
    } exp_t;

    localparam exp_t Z = '0;

    exp_t  exp_q[$];
    string name_q[$];
    exp_t  mon_want, mon_got;
    string mon_nm;
    int    total = 0;
    int    bad   = 0;

    function automatic id_t nop();
        return '0;
    endfunction

    function automatic id_t alum(logic [4:0] rd, logic [4:0] a, logic [4:0] b, logic [1:0] used);
        id_t r = '0;
        r.v = 1'b1; r.rd = rd; r.rw = 1'b1; r.rs0 = a; r.rs1 = b; r.used = used;
        return r;
    endfunction

    function automatic id_t alu(logic [4:0] rd, logic [4:0] a, logic [4:0] b);
        return alum(rd, a, b, 2'b11);
    endfunction

    function automatic id_t lw(logic [4:0] rd, logic [4:0] a);
        id_t r = alum(rd, a, 5'd0, 2'b01);
        r.ld = 1'b1;
        return r;
    endfunction

    function automatic id_t mul(logic [4:0] rd, logic [4:0] a, logic [4:0] b);
        id_t r = alu(rd, a, b);
        r.mc = 1'b1;
        return r;
    endfunction

    function automatic id_t jalr(logic [4:0] a);
        id_t r = alum(5'd0, a, 5'd0, 2'b01);
        r.jr = 1'b1;
        return r;
    endfunction

    function automatic exp_t e(logic s, logic b, logic h, logic m, logic [3:0] f, logic [1:0] j);
        exp_t r;
        r.stall = s; r.bubble = b; r.hold = h; r.busy = m; r.fwd = f; r.jfwd = j;
        return r;
    endfunction

    task automatic step(input id_t id, input logic fl, input logic rn, input exp_t ex,
                        input string nm);
        rst_n           = rn;
        hz.id_valid     = id.v;
        hz.id_rd        = id.rd;
        hz.id_reg_write = id.rw;
        hz.id_is_load   = id.ld;
        hz.id_is_mc     = id.mc;
        hz.id_is_jalr   = id.jr;
        hz.id_rs        = {id.rs1, id.rs0};
        hz.id_rs_used   = id.used;
        hz.flush_id_ex  = fl;
        exp_q.push_back(ex);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_want = exp_q.pop_front();
            mon_nm   = name_q.pop_front();
            mon_got  = {hz.stall_front, hz.bubble_ex, hz.ex_hold, hz.mc_busy,
                        hz.fwd_sel, hz.jalr_fwd_sel};
            total++;
            if (mon_got !== mon_want) begin
                bad++;
                $display("FAIL %s: got stall,bubble,hold,busy,fwd,jfwd=%b required=%b",
                         mon_nm, mon_got, mon_want);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        step(nop(), 1'b0, 1'b0, Z, "init_reset");
        repeat (2) @(posedge clk);
        #1;
        step(nop(), 1'b0, 1'b0, Z, "reset_state");

        // back-to-back, one-gap and MEM-vs-WB priority forwarding
        step(alu(5, 1, 2),  1'b0, 1'b1, Z, "a_add_x5");
        step(alu(6, 5, 5),  1'b0, 1'b1, Z, "a_sub_in_id");
        step(nop(),         1'b0, 1'b1, e(0,0,0,0,4'b1010,2'b00), "a_fwd_mem_both");
        step(alu(5, 1, 2),  1'b0, 1'b1, Z, "a_add_x5_again");
        step(nop(),         1'b0, 1'b1, Z, "a_gap");
        step(alu(7, 5, 5),  1'b0, 1'b1, Z, "a_use_after_gap");
        step(alu(5, 3, 4),  1'b0, 1'b1, e(0,0,0,0,4'b0101,2'b00), "a_fwd_wb_both");
        step(alu(5, 0, 0),  1'b0, 1'b1, Z, "a_second_x5");
        step(alu(9, 5, 0),  1'b0, 1'b1, Z, "a_x0_sources");
        step(nop(),         1'b0, 1'b1, e(0,0,0,0,4'b0010,2'b00), "a_mem_wins");
        step(nop(),         1'b0, 1'b1, Z, "a_drain0");
        step(nop(),         1'b0, 1'b1, Z, "a_drain1");

        // load-use, x0 load, unused source
        step(lw(7, 1),      1'b0, 1'b1, Z, "b_lw_x7");
        step(alu(8, 7, 1),  1'b0, 1'b1, e(1,1,0,0,4'b0000,2'b00), "b_load_use");
        step(alu(8, 7, 1),  1'b0, 1'b1, Z, "b_after_stall");
        step(nop(),         1'b0, 1'b1, e(0,0,0,0,4'b0001,2'b00), "b_fwd_wb_load");
        step(lw(0, 1),      1'b0, 1'b1, Z, "b_lw_x0");
        step(alu(11, 0, 0), 1'b0, 1'b1, Z, "b_x0_no_stall");
        step(nop(),         1'b0, 1'b1, Z, "b_x0_no_fwd");
        step(lw(7, 1),      1'b0, 1'b1, Z, "b_lw_x7_again");
        step(alum(12, 2, 7, 2'b01), 1'b0, 1'b1, Z, "b_unused_no_stall");
        step(nop(),         1'b0, 1'b1, Z, "b_unused_no_fwd");
        step(nop(),         1'b0, 1'b1, Z, "b_drain0");
        step(nop(),         1'b0, 1'b1, Z, "b_drain1");

        // multi-cycle op; flush while busy is ignored
        step(mul(9, 1, 2),  1'b0, 1'b1, Z, "c_div_x9");
        step(alu(10, 9, 2), 1'b0, 1'b1, e(1,0,1,1,4'b0000,2'b00), "c_busy1");
        step(alu(10, 9, 2), 1'b1, 1'b1, e(1,0,1,1,4'b0000,2'b00), "c_busy2_flush");
        step(alu(10, 9, 2), 1'b0, 1'b1, e(1,0,1,1,4'b0000,2'b00), "c_busy3");
        step(alu(10, 9, 2), 1'b0, 1'b1, Z, "c_last_ex_cycle");
        step(nop(),         1'b0, 1'b1, e(0,0,0,0,4'b0010,2'b00), "c_fwd_from_div");
        step(nop(),         1'b0, 1'b1, Z, "c_drain0");
        step(nop(),         1'b0, 1'b1, Z, "c_drain1");

        // JALR after ALU (1 stall) and after load (2 stalls)
        step(alu(1, 3, 4),  1'b0, 1'b1, Z, "d_addi_x1");
        step(jalr(1),       1'b0, 1'b1, e(1,1,0,0,4'b0000,2'b00), "d_jalr_stall_ex");
        step(jalr(1),       1'b0, 1'b1, e(0,0,0,0,4'b0000,2'b10), "d_jalr_fwd_mem");
        step(nop(),         1'b0, 1'b1, e(0,0,0,0,4'b0001,2'b00), "d_jalr_in_ex");
        step(lw(1, 2),      1'b0, 1'b1, Z, "d_lw_x1");
        step(jalr(1),       1'b0, 1'b1, e(1,1,0,0,4'b0000,2'b00), "d_jalr_stall_ld_ex");
        step(jalr(1),       1'b0, 1'b1, e(1,1,0,0,4'b0000,2'b10), "d_jalr_stall_ld_mem");
        step(jalr(1),       1'b0, 1'b1, e(0,0,0,0,4'b0000,2'b01), "d_jalr_fwd_wb");
        step(nop(),         1'b0, 1'b1, Z, "d_drain0");
        step(nop(),         1'b0, 1'b1, Z, "d_drain1");

        // flush squashes ID; flush with load-use gives one bubble
        step(alu(5, 1, 2),  1'b1, 1'b1, e(0,1,0,0,4'b0000,2'b00), "e_flush");
        step(alu(13, 5, 5), 1'b0, 1'b1, Z, "e_after_flush");
        step(nop(),         1'b0, 1'b1, Z, "e_no_fwd_squashed");
        step(lw(7, 1),      1'b0, 1'b1, Z, "e_lw_x7");
        step(alu(8, 7, 7),  1'b1, 1'b1, e(1,1,0,0,4'b0000,2'b00), "e_flush_and_load_use");
        step(alu(8, 7, 7),  1'b0, 1'b1, Z, "e_single_bubble");
        step(nop(),         1'b0, 1'b1, e(0,0,0,0,4'b0101,2'b00), "e_fwd_wb_load");
        step(nop(),         1'b0, 1'b1, Z, "e_drain0");
        step(nop(),         1'b0, 1'b1, Z, "e_drain1");

        // asynchronous reset mid-stream and mid multi-cycle op
        step(lw(7, 1),      1'b0, 1'b1, Z, "f_lw_x7");
        step(alu(8, 7, 1),  1'b0, 1'b0, Z, "f_reset_clears_stall");
        step(nop(),         1'b0, 1'b1, Z, "f_release");
        step(alu(8, 7, 1),  1'b0, 1'b1, Z, "f_no_stall_after_reset");
        step(nop(),         1'b0, 1'b1, Z, "f_no_stale_fwd");
        step(mul(9, 1, 2),  1'b0, 1'b1, Z, "f_div");
        step(nop(),         1'b0, 1'b1, e(1,0,1,1,4'b0000,2'b00), "f_busy");
        step(nop(),         1'b0, 1'b0, Z, "f_reset_clears_busy");
        step(nop(),         1'b0, 1'b1, Z, "f_op_abandoned");
        step(nop(),         1'b0, 1'b1, Z, "f_idle");

        @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: pending=%0d required=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
